// File: rtl/board_drawer.sv
// -----------------------------------------------------------------------------
// board_drawer
//
// Sequential renderer for the tic-tac-toe board. Walks the nine cells in
// row-major order, presents each index to an external combinational
// position/colour decoder, latches the returned top-left corner and colour,
// then streams a filled CELL_SIZE x CELL_SIZE square into the VGA adapter's
// plot interface at one pixel per clock.
//
// Parameters:
//   CELL_SIZE    side of each square in pixels, legal range 2..30
//
// Ports:
//   clock        system clock, rising-edge active
//   resetn       asynchronous active-low reset
//   start        redraw request, only sampled while idle
//   cell_idx     cell index (0..8) driven to the decoder
//   cell_x       decoder top-left x for cell_idx
//   cell_y       decoder top-left y for cell_idx
//   cell_colour  decoder colour for cell_idx
//   vga_x        pixel x to plot
//   vga_y        pixel y to plot
//   vga_colour   pixel colour to plot
//   plot         VGA write enable, high only for valid pixels
//   busy         high while a redraw is in progress (LATCH and DRAW)
//   done         one-cycle pulse after the last pixel of a redraw
//
// Build option:
//   BOARD_DRAWER_BORDER_EN  when defined, the outer ring of every square is
//                           drawn black; the interior keeps the cell colour.
//
// Every output comes straight from a register, so there is no combinational
// path from start or the decoder inputs to plot or the vga_* outputs.
// -----------------------------------------------------------------------------

module board_drawer #(
    parameter int unsigned CELL_SIZE = 26
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    output logic [3:0] cell_idx,
    input  logic [7:0] cell_x,
    input  logic [6:0] cell_y,
    input  logic [2:0] cell_colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] LAST_OFFSET = 5'(CELL_SIZE - 1);
    localparam logic [3:0] LAST_CELL   = 4'd8;

`ifdef BOARD_DRAWER_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StLatch,
        StDraw,
        StDone
    } state_t;

    state_t     r_state;
    logic [3:0] r_cell;
    logic [7:0] r_base_x;
    logic [6:0] r_base_y;
    logic [2:0] r_col;
    logic [4:0] r_dx;
    logic [4:0] r_dy;
    logic [7:0] r_vga_x;
    logic [6:0] r_vga_y;
    logic [2:0] r_vga_colour;
    logic       r_plot;
    logic       r_busy;
    logic       r_done;

    logic       w_dx_last;
    logic       w_dy_last;
    logic [4:0] w_dx_next;
    logic [4:0] w_dy_next;
    logic [7:0] w_next_x;
    logic [6:0] w_next_y;

    // Colour of the pixel at offset (dx, dy) within a square of colour col.
    function automatic logic [2:0] f_pixel_colour(input logic [4:0] dx,
                                                  input logic [4:0] dy,
                                                  input logic [2:0] col);
        logic w_edge;
        w_edge = (dx == 5'd0) || (dx == LAST_OFFSET) ||
                 (dy == 5'd0) || (dy == LAST_OFFSET);
        if (BORDER_EN && w_edge) begin
            return 3'b000;
        end
        return col;
    endfunction

    // Offsets of the pixel that follows the current one inside the square.
    // Only used when the current pixel is not the last of the square.
    always_comb begin
        w_dx_last = (r_dx == LAST_OFFSET);
        w_dy_last = (r_dy == LAST_OFFSET);
        w_dx_next = w_dx_last ? 5'd0 : (r_dx + 5'd1);
        w_dy_next = w_dx_last ? (r_dy + 5'd1) : r_dy;
        // Sums cannot overflow for CELL_SIZE <= 30 (max x 126, max y 96).
        w_next_x  = r_base_x + {3'b000, w_dx_next};
        w_next_y  = r_base_y + {2'b00, w_dy_next};
    end

    // The vga_* registers hold the pixel being presented this cycle, so each
    // edge loads the coordinates and colour of the pixel that follows.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= StIdle;
            r_cell       <= 4'd0;
            r_base_x     <= 8'd0;
            r_base_y     <= 7'd0;
            r_col        <= 3'd0;
            r_dx         <= 5'd0;
            r_dy         <= 5'd0;
            r_vga_x      <= 8'd0;
            r_vga_y      <= 7'd0;
            r_vga_colour <= 3'd0;
            r_plot       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_plot <= 1'b0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_cell  <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= StLatch;
                    end
                end

                StLatch: begin
                    // Position and colour are frozen here for the whole square;
                    // later decoder changes only matter from the next latch.
                    r_base_x     <= cell_x;
                    r_base_y     <= cell_y;
                    r_col        <= cell_colour;
                    r_dx         <= 5'd0;
                    r_dy         <= 5'd0;
                    r_vga_x      <= cell_x;
                    r_vga_y      <= cell_y;
                    r_vga_colour <= f_pixel_colour(5'd0, 5'd0, cell_colour);
                    r_plot       <= 1'b1;
                    r_state      <= StDraw;
                end

                StDraw: begin
                    if (w_dx_last && w_dy_last) begin
                        // Last pixel of this square: plot drops so a latch
                        // cycle with plot low always separates two cells.
                        r_plot <= 1'b0;
                        r_dx   <= 5'd0;
                        r_dy   <= 5'd0;
                        if (r_cell == LAST_CELL) begin
                            r_cell  <= 4'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_cell  <= r_cell + 4'd1;
                            r_state <= StLatch;
                        end
                    end else begin
                        r_dx         <= w_dx_next;
                        r_dy         <= w_dy_next;
                        r_vga_x      <= w_next_x;
                        r_vga_y      <= w_next_y;
                        r_vga_colour <= f_pixel_colour(w_dx_next, w_dy_next, r_col);
                    end
                end

                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign cell_idx   = r_cell;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign plot       = r_plot;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_board_drawer.sv
// -----------------------------------------------------------------------------
// tb_board_drawer
//
// Directed bench for board_drawer. Drives a CELL_SIZE=26 instance through full
// redraws (mixed colours, start held high, decoder change mid-square, reset
// mid-redraw) and a CELL_SIZE=4 instance for the outline option. Expected
// pixels come from a position/colour model written in the bench.
// -----------------------------------------------------------------------------

module tb_board_drawer;

    localparam int CS  = 26;
    localparam int CS4 = 4;

`ifdef BOARD_DRAWER_BORDER_EN
    localparam bit TB_BORDER = 1'b1;
`else
    localparam bit TB_BORDER = 1'b0;
`endif

    logic       clock;
    logic       resetn;
    logic       start;
    logic [3:0] cell_idx;
    logic [7:0] cell_x;
    logic [6:0] cell_y;
    logic [2:0] cell_colour;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    logic       start4;
    logic [3:0] cell_idx4;
    logic [7:0] cell_x4;
    logic [6:0] cell_y4;
    logic [2:0] cell_colour4;
    logic [7:0] vga_x4;
    logic [6:0] vga_y4;
    logic [2:0] vga_colour4;
    logic       plot4;
    logic       busy4;
    logic       done4;

    logic [2:0] dec_cols [9];
    logic [2:0] exp_cols [9];

    int n_cmp;
    int n_err;

    int s_plot, s_runs, s_busy, s_done, s_done_at, s_first_k;
    int s_first_x, s_first_y, s_last_x, s_last_y, s_pix_err;
    int s_last_cell, s_last_plot;

    board_drawer #(.CELL_SIZE(CS)) u_dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .cell_idx    (cell_idx),
        .cell_x      (cell_x),
        .cell_y      (cell_y),
        .cell_colour (cell_colour),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    board_drawer #(.CELL_SIZE(CS4)) u_dut4 (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start4),
        .cell_idx    (cell_idx4),
        .cell_x      (cell_x4),
        .cell_y      (cell_y4),
        .cell_colour (cell_colour4),
        .vga_x       (vga_x4),
        .vga_y       (vga_y4),
        .vga_colour  (vga_colour4),
        .plot        (plot4),
        .busy        (busy4),
        .done        (done4)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] dec_x(input logic [3:0] i);
        case (i)
            4'd0, 4'd3, 4'd6: return 8'd37;
            4'd1, 4'd4, 4'd7: return 8'd67;
            default:          return 8'd97;
        endcase
    endfunction

    function automatic logic [6:0] dec_y(input logic [3:0] i);
        case (i)
            4'd0, 4'd1, 4'd2: return 7'd7;
            4'd3, 4'd4, 4'd5: return 7'd37;
            default:          return 7'd67;
        endcase
    endfunction

    // Combinational decoder models for both instances.
    always_comb begin
        cell_x       = dec_x(cell_idx);
        cell_y       = dec_y(cell_idx);
        cell_colour  = (cell_idx <= 4'd8) ? dec_cols[cell_idx] : 3'b000;
        cell_x4      = dec_x(cell_idx4);
        cell_y4      = dec_y(cell_idx4);
        cell_colour4 = 3'b111;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected colour of pixel p of run r in the 26-pixel instance.
    function automatic logic [2:0] exp_col(input int r, input int p);
        int dx;
        int dy;
        dx = p % CS;
        dy = p / CS;
        if (TB_BORDER && (dx == 0 || dx == CS - 1 || dy == 0 || dy == CS - 1)) begin
            return 3'b000;
        end
        return exp_cols[r];
    endfunction

    // Drive start high across one rising edge; leave it high when hold is set.
    task automatic pulse_start(input bit hold);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Sample the 26-pixel instance each cycle after start was taken (k=1 is
    // the cycle after the accepting edge) until done, abort_at or limit.
    task automatic watch(input int limit, input int abort_at, input int chg_at,
                         input logic [2:0] chg_col);
        int r;
        int p;
        logic prev_plot;
        logic [7:0] ex;
        logic [6:0] ey;
        s_plot = 0; s_runs = 0; s_busy = 0; s_done = 0; s_done_at = 0;
        s_first_k = 0; s_first_x = -1; s_first_y = -1; s_last_x = -1; s_last_y = -1;
        s_pix_err = 0; s_last_cell = -1; s_last_plot = -1;
        r = -1;
        p = 0;
        prev_plot = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clock);
            if (k == chg_at) dec_cols[2] = chg_col;
            if (plot) begin
                s_plot++;
                if (!prev_plot) begin
                    r++;
                    p = 0;
                    s_runs++;
                end
                if (s_plot == 1) begin
                    s_first_k = k;
                    s_first_x = int'(vga_x);
                    s_first_y = int'(vga_y);
                end
                s_last_x = int'(vga_x);
                s_last_y = int'(vga_y);
                if (r > 8) begin
                    s_pix_err++;
                end else begin
                    ex = 8'(37 + 30 * (r % 3) + p % CS);
                    ey = 7'(7 + 30 * (r / 3) + p / CS);
                    if (vga_x !== ex || vga_y !== ey || vga_colour !== exp_col(r, p) ||
                        int'(cell_idx) != r) begin
                        s_pix_err++;
                    end
                end
                p++;
            end
            if (busy) s_busy++;
            if (done) begin
                s_done++;
                s_done_at = k;
            end
            prev_plot = plot;
            s_last_cell = int'(cell_idx);
            s_last_plot = int'(plot);
            if (done || k == abort_at) break;
        end
    endtask

    initial begin
        int n_white;
        int n_black;
        int c00;
        int c11;
        int d4;
        int n_extra_done;

        n_cmp  = 0;
        n_err  = 0;
        clock  = 1'b0;
        resetn = 1'b0;
        start  = 1'b0;
        start4 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            dec_cols[i] = 3'b111;
            exp_cols[i] = 3'b111;
        end

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_plot",  32'(plot), 0);
        check_eq("rst_busy",  32'(busy), 0);
        check_eq("rst_done",  32'(done), 0);
        check_eq("rst_idx",   32'(cell_idx), 0);
        check_eq("rst_x",     32'(vga_x), 0);
        check_eq("rst_y",     32'(vga_y), 0);
        check_eq("rst_col",   32'(vga_colour), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // Full redraw, cell 4 = 011, cell 8 = 101
        dec_cols[4] = 3'b011; exp_cols[4] = 3'b011;
        dec_cols[8] = 3'b101; exp_cols[8] = 3'b101;
        pulse_start(1'b0);
        watch(7000, 0, 0, 3'b000);
        check_eq("a_plot_cnt", s_plot, 6084);
        check_eq("a_runs",     s_runs, 9);
        check_eq("a_busy_cnt", s_busy, 6093);
        check_eq("a_first_k",  s_first_k, 2);
        check_eq("a_first_x",  s_first_x, 37);
        check_eq("a_first_y",  s_first_y, 7);
        check_eq("a_last_x",   s_last_x, 122);
        check_eq("a_last_y",   s_last_y, 92);
        check_eq("a_pix_err",  s_pix_err, 0);
        check_eq("a_done_cnt", s_done, 1);
        check_eq("a_done_at",  s_done_at, 6094);
        check_eq("a_idle_idx", 32'(cell_idx), 0);
        @(negedge clock);
        check_eq("a_done_1cy", 32'(done), 0);

        // Decoder colour for cell 2 changes in the middle of its square
        dec_cols[4] = 3'b111; exp_cols[4] = 3'b111;
        dec_cols[8] = 3'b111; exp_cols[8] = 3'b111;
        pulse_start(1'b0);
        watch(7000, 0, 1500, 3'b001);
        check_eq("b_pix_err", s_pix_err, 0);
        check_eq("b_done_at", s_done_at, 6094);
        dec_cols[2] = 3'b111;
        @(negedge clock);

        // start held high through an entire redraw
        pulse_start(1'b1);
        watch(7000, 0, 0, 3'b000);
        check_eq("c_done_cnt", s_done, 1);
        check_eq("c_done_at",  s_done_at, 6094);
        check_eq("c_plot_cnt", s_plot, 6084);
        @(negedge clock);
        check_eq("c_idle_busy", 32'(busy), 0);
        @(negedge clock);
        check_eq("c_relatch_busy", 32'(busy), 1);
        check_eq("c_relatch_plot", 32'(plot), 0);
        @(negedge clock);
        check_eq("c_redraw_plot", 32'(plot), 1);
        check_eq("c_redraw_x",    32'(vga_x), 37);
        check_eq("c_redraw_y",    32'(vga_y), 7);
        start  = 1'b0;
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Reset during the square of cell 5
        pulse_start(1'b0);
        watch(7000, 3500, 0, 3'b000);
        check_eq("d_pre_cell", s_last_cell, 5);
        check_eq("d_pre_plot", s_last_plot, 1);
        resetn = 1'b0;
        #1;
        check_eq("d_rst_plot", 32'(plot), 0);
        check_eq("d_rst_busy", 32'(busy), 0);
        check_eq("d_rst_idx",  32'(cell_idx), 0);
        check_eq("d_rst_x",    32'(vga_x), 0);
        @(negedge clock);
        resetn = 1'b1;
        n_extra_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (done || busy || plot) n_extra_done++;
        end
        check_eq("d_no_done", n_extra_done, 0);
        pulse_start(1'b0);
        watch(7000, 0, 0, 3'b000);
        check_eq("d_first_k", s_first_k, 2);
        check_eq("d_first_x", s_first_x, 37);
        check_eq("d_first_y", s_first_y, 7);
        check_eq("d_pix_err", s_pix_err, 0);
        check_eq("d_done_at", s_done_at, 6094);

        // CELL_SIZE = 4 instance, all cells white
        @(negedge clock);
        start4 = 1'b1;
        @(posedge clock);
        #1;
        start4 = 1'b0;
        n_white = 0; n_black = 0; c00 = -1; c11 = -1; d4 = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clock);
            if (plot4) begin
                if (vga_colour4 == 3'b111) n_white++;
                else if (vga_colour4 == 3'b000) n_black++;
                if (cell_idx4 == 4'd0 && vga_x4 == 8'd37 && vga_y4 == 7'd7) c00 = int'(vga_colour4);
                if (cell_idx4 == 4'd0 && vga_x4 == 8'd38 && vga_y4 == 7'd8) c11 = int'(vga_colour4);
            end
            if (done4) begin
                d4 = k;
                break;
            end
        end
        check_eq("e_white",   n_white, TB_BORDER ? 36 : 144);
        check_eq("e_black",   n_black, TB_BORDER ? 108 : 0);
        check_eq("e_px37_7",  c00, TB_BORDER ? 0 : 7);
        check_eq("e_px38_8",  c11, 7);
        check_eq("e_done_at", d4, 154);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/board_drawer.md
# board_drawer

Sequential renderer for the tic-tac-toe board. It walks the nine cells in row-major order and presents each cell index to the combinational position/colour decoder. It latches the returned top-left coordinate and colour, then streams a filled CELL_SIZE × CELL_SIZE square, one pixel per clock, into the VGA adapter's plot interface. It sits between the game-state logic (which pulses `start` whenever the grid changes) and the VGA adapter.

## Interface
- `CELL_SIZE`, default 26: side of each drawn square in pixels. Legal range 2..30; the square must stay inside the 30-pixel cell pitch.
- `clock` input 1: system clock; all state changes on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: request a full board redraw; sampled only in IDLE.
- `cell_idx` output 4: cell currently selected for the decoder, 0..8, row-major from top-left. Cell k corresponds to grid bits [17-2k:16-2k].
- `cell_x` input 8: decoder top-left x for `cell_idx` (37/67/97), valid combinationally.
- `cell_y` input 7: decoder top-left y for `cell_idx` (7/37/67).
- `cell_colour` input 3: decoder colour for `cell_idx`.
- `vga_x` output 8: pixel x to plot.
- `vga_y` output 7: pixel y to plot.
- `vga_colour` output 3: pixel colour to plot.
- `plot` output 1: write-enable to the VGA adapter; high exactly for valid pixels.
- `busy` output 1: high while a redraw is in progress.
- `done` output 1: one-cycle pulse when a redraw completes.

## Operation
- States: IDLE, LATCH, DRAW, DONE.
- IDLE:
  - `cell_idx`=0, `plot`=0, `busy`=0.
  - `start`=1 moves to LATCH with cell index 0.
- LATCH (1 cycle):
  - `cell_idx` drives the decoder.
  - At the clock edge, `cell_x`/`cell_y`/`cell_colour` are captured into base_x/base_y/col registers, and the offsets are cleared (dx=0, dy=0).
  - Next state is DRAW.
- DRAW (CELL_SIZE² cycles):
  - `plot`=1, `vga_x`=base_x+dx, `vga_y`=base_y+dy, `vga_colour`=col.
  - dx increments every cycle. On dx=CELL_SIZE-1, dx wraps to 0 and dy increments.
  - On dx=dy=CELL_SIZE-1: if cell index is 8, go to DONE; otherwise increment the cell index and go to LATCH.
- DONE (1 cycle): `done`=1, `plot`=0, then IDLE.
- `busy`=1 in LATCH and DRAW.
- `start` is ignored in LATCH, DRAW and DONE; there is no queuing.
- Colour and position are latched per cell. Decoder input changes during DRAW do not affect the square in progress; they take effect from the next LATCH.
- Arithmetic:
  - dx and dy are 5-bit unsigned counters.
  - Coordinate sums are computed at output width (8-bit x, 7-bit y) with no overflow, given the legal CELL_SIZE range (max x 126, max y 96).
- Reset (any state, any time):
  - State returns to IDLE; `plot`, `busy` and `done` go to 0 immediately.
  - `cell_idx`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0.
  - Counters and latches clear.
  - A partially drawn board is not resumed.

## Timing
- `start` sampled high in IDLE at edge N: LATCH occupies cycle N+1, and the first `plot` is in cycle N+2.
- Per cell: 1 LATCH cycle + CELL_SIZE² DRAW cycles. Full board: 9·(1+CELL_SIZE²) cycles with `busy`=1; this is 6093 for CELL_SIZE=26.
- `done` is asserted in the cycle immediately after the last `plot`. IDLE follows, and a new `start` is accepted in the cycle after `done`.
- `plot` is never high in two different cells without an intervening LATCH cycle with `plot`=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `start` or the decoder inputs to `plot` or the `vga_*` outputs.

## Configuration
- `BOARD_DRAWER_BORDER_EN`:
  - Defined: during DRAW, pixels with dx∈{0,CELL_SIZE-1} or dy∈{0,CELL_SIZE-1} use `vga_colour`=3'b000 (black outline). Interior pixels use the latched colour. Cycle counts are unchanged.
  - Undefined: every pixel of the square uses the latched colour.

## Test plan
- Reset, then `start` pulse with the decoder model returning 3'b111 for all cells, CELL_SIZE=26:
  - `plot` is high for exactly 6084 cycles, in 9 runs of 676.
  - First pixel (37,7), last pixel (122,92).
  - `done` pulses once, 6094 cycles after `start`.
- Cell 4 decodes to 3'b011 and cell 8 to 3'b101, all others 3'b111: all pixels of run 4 are 3'b011 at x 67..92, y 37..62; all pixels of run 8 are 3'b101.
- `start` held high through an entire redraw: exactly one redraw, and a second one begins the cycle after `done` (`start` still high).
- Decoder colour for cell 2 changes mid-DRAW of cell 2: the whole cell-2 square keeps the colour latched at LATCH.
- `resetn` pulled low during the DRAW of cell 5: `plot`/`busy` drop within the same cycle, no `done` pulse, and the next `start` redraws from cell 0 at (37,7).
- With `BOARD_DRAWER_BORDER_EN`, CELL_SIZE=4, all cells 3'b111: each square plots 12 black pixels and 4 white pixels. For cell 0, (38,8) is white and (37,7) is black.
